// File: rtl/mul8_seq.sv
// -----------------------------------------------------------------------------
// mul8_seq -- sequential 8x8 -> 16-bit shift-and-add multiplier.
//
// An add8 instance forms acc + mcand every cycle. The FSM decides per cycle
// whether the sum or the plain accumulator is shifted into {acc, q}. After
// eight iterations {acc, q} holds the product.
//
// Parameters:
//   DONE_STICKY  0: done is a one-cycle pulse
//                1: done is held until the next start is accepted
//
// Optional build macro:
//   MUL8_SIGNED_EN  two's-complement operands. The magnitudes are multiplied.
//                   Products with a negative sign take one extra NEG cycle
//                   to negate the result.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   request, sampled when busy=0
//   a      in   8   multiplicand, sampled with start
//   b      in   8   multiplier, sampled with start
//   busy   out  1   multiply in progress
//   done   out  1   product-valid strobe (see DONE_STICKY)
//   p      out  16  product register, held until the next completion
// -----------------------------------------------------------------------------

module add8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       ci_i,
    output logic [7:0] s_o,
    output logic       co_o
);
    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, ci_i};
endmodule

module mul8_seq #(
    parameter bit DONE_STICKY = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p
);

    // state  | meaning
    // IDLE   | waiting for start
    // RUN    | eight shift-and-add iterations
    // NEG    | negate magnitude product (signed build only)
    // DONE   | product valid; start accepted here as in IDLE
`ifdef MUL8_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_NEG} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t      state_q;
    logic [7:0]  mcand_q;
    logic [7:0]  acc_q;
    logic [7:0]  q_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] p_q;
`ifdef MUL8_SIGNED_EN
    logic        neg_q;
`endif

    logic [7:0]  add_s;
    logic        add_co;
    logic [7:0]  acc_step;
    logic [7:0]  q_step;
    logic [7:0]  a_ld;
    logic [7:0]  b_ld;

    add8 u_add8 (
        .a_i  (acc_q),
        .b_i  (mcand_q),
        .ci_i (1'b0),
        .s_o  (add_s),
        .co_o (add_co)
    );

    // The carry-out becomes the new acc MSB, so the 9-bit sum is never lost.
    always_comb begin
        acc_step = {1'b0, acc_q[7:1]};
        q_step   = {acc_q[0], q_q[7:1]};
        if (q_q[0]) begin
            acc_step = {add_co, add_s[7:1]};
            q_step   = {add_s[0], q_q[7:1]};
        end
    end

`ifdef MUL8_SIGNED_EN
    // -128 negates to 8'h80. That value is then used as unsigned 128.
    assign a_ld = a[7] ? (~a + 8'd1) : a;
    assign b_ld = b[7] ? (~b + 8'd1) : b;
`else
    assign a_ld = a;
    assign b_ld = b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mcand_q <= 8'd0;
            acc_q   <= 8'd0;
            q_q     <= 8'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= 16'd0;
`ifdef MUL8_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mcand_q <= a_ld;
                        q_q     <= b_ld;
                        acc_q   <= 8'd0;
                        cnt_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_RUN;
`ifdef MUL8_SIGNED_EN
                        neg_q   <= a[7] ^ b[7];
`endif
                    end else if (state_q == S_DONE && !DONE_STICKY) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_step;
                    q_q   <= q_step;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
`ifdef MUL8_SIGNED_EN
                        if (neg_q) begin
                            state_q <= S_NEG;
                        end else begin
                            p_q     <= {acc_step, q_step};
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
`else
                        p_q     <= {acc_step, q_step};
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef MUL8_SIGNED_EN
                S_NEG: begin
                    // A zero magnitude negates to zero in 16 bits, so no special case is needed.
                    p_q     <= ~{acc_q, q_q} + 16'd1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule
